// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM state and counter width.
// The ALU_ARBITER_STATS_EN build uses CNT_W to size the grant counters.
package alu_arbiter_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Team 4-bit ALU: add, sub, and, or. Add and sub wrap modulo 16 and have no carry output.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [1:0] op_i,
  output logic [3:0] y_o
);

  always_comb begin
    y_o = 4'h0;
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      default: y_o = 4'h0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 4-bit ALU between two valid/ready requesters, one result slot.
// Optional macro ALU_ARBITER_STATS_EN adds saturating per-requester grant counters.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter logic RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req1_op,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       res_id
`ifdef ALU_ARBITER_STATS_EN
  ,
  output logic [CNT_W-1:0] grant0_cnt,
  output logic [CNT_W-1:0] grant1_cnt
`endif
);

  state_e     state_q, state_d;
  logic       prio_q, prio_d;
  logic [3:0] data_q, data_d;
  logic       id_q, id_d;

  logic       any_vld;
  logic       gnt;
  logic       can_acc;
  logic       acc;
  logic [3:0] mux_a, mux_b;
  logic [1:0] mux_op;
  logic [3:0] alu_y;

  // Grant: lone requester wins; on contention the priority holder wins.
  always_comb begin
    any_vld = req0_valid | req1_valid;
    gnt     = (req0_valid & req1_valid) ? prio_q : req1_valid;
    can_acc = (state_q == ST_IDLE) | res_ready;
    acc     = can_acc & any_vld;
    mux_a   = gnt ? req1_a  : req0_a;
    mux_b   = gnt ? req1_b  : req0_b;
    mux_op  = gnt ? req1_op : req0_op;
  end

  assign req0_ready = acc & ~gnt;
  assign req1_ready = acc & gnt;

  alu_arbiter_alu u_alu (
    .a_i  (mux_a),
    .b_i  (mux_b),
    .op_i (mux_op),
    .y_o  (alu_y)
  );

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    data_d  = data_q;
    id_d    = id_q;
    if (acc) begin
      state_d = ST_BUSY;
      data_d  = alu_y;
      id_d    = gnt;
      prio_d  = ~gnt;
    end else if ((state_q == ST_BUSY) && res_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      prio_q  <= RR_INIT;
      data_q  <= 4'h0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign res_valid = (state_q == ST_BUSY);
  assign res_data  = data_q;
  assign res_id    = id_q;

`ifdef ALU_ARBITER_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (req0_ready) cnt0_d = sat_inc(cnt0_q);
    if (req1_ready) cnt1_d = sat_inc(cnt1_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant0_cnt = cnt0_q;
  assign grant1_cnt = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed stimulus queues expected {id,data}; a monitor pops on each result transfer.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic       res_valid, res_ready, res_id;
  logic [3:0] res_data;
`ifdef ALU_ARBITER_STATS_EN
  logic [CNT_W-1:0] grant0_cnt, grant1_cnt;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id)
`ifdef ALU_ARBITER_STATS_EN
    ,
    .grant0_cnt (grant0_cnt),
    .grant1_cnt (grant1_cnt)
`endif
  );

  typedef logic [4:0] exp_t;
  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit sel, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    if (sel) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  // Issue one request from a lone requester; caller sits just after a rising edge.
  task automatic single(input string nm, input bit sel, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] op, input logic [3:0] exp);
    set_req(sel, a, b, op);
    @(negedge clk);
    chk({nm, "_ready"}, {6'b0, req1_ready, req0_ready}, sel ? 8'h2 : 8'h1);
    sbq.push_back({sel, exp});
    step();
    if (sel) req1_valid = 1'b0;
    else     req0_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) step();
    if (sbq.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d results outstanding, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    res_ready = 1'b1;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!reset && res_valid && res_ready) begin
          if (sbq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: got id=%0d data=0x%0h, expected none", res_id, res_data);
          end else begin
            e = sbq.pop_front();
            chk("result_id_data", {3'b0, res_id, res_data}, {3'b0, e});
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("reset_res_valid", {7'b0, res_valid}, 8'h0);
    chk("reset_res_data",  {4'b0, res_data},  8'h0);
    chk("reset_res_id",    {7'b0, res_id},    8'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_ready", {6'b0, req1_ready, req0_ready}, 8'h0);
    step();

    // Single request: 3 + 5 = 8 from req0
    single("single", 1'b0, 4'h3, 4'h5, OP_ADD, 4'h8);
    drain();

    // Wrap and logic ops, back to back
    single("sub_wrap", 1'b0, 4'h0, 4'h1, OP_SUB, 4'hF);
    single("add_wrap", 1'b1, 4'hF, 4'h1, OP_ADD, 4'h0);
    single("and_op",   1'b0, 4'hC, 4'hA, OP_AND, 4'h8);
    single("or_op",    1'b1, 4'hC, 4'hA, OP_OR,  4'hE);
    drain();

    // Contention from reset: grants alternate 0,1,0,1 at full rate
    pulse_reset();
    set_req(1'b0, 4'h1, 4'h1, OP_ADD);
    set_req(1'b1, 4'h7, 4'h2, OP_SUB);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("contend_ready", {6'b0, req1_ready, req0_ready}, k[0] ? 8'h2 : 8'h1);
      sbq.push_back(k[0] ? {1'b1, 4'h5} : {1'b0, 4'h2});
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Backpressure: result 0xA held for 5 cycles while req1 waits
    res_ready = 1'b0;
    set_req(1'b0, 4'h5, 4'h5, OP_ADD);
    @(negedge clk);
    chk("bp_accept_ready", {6'b0, req1_ready, req0_ready}, 8'h1);
    sbq.push_back({1'b0, 4'hA});
    step();
    req0_valid = 1'b0;
    set_req(1'b1, 4'h3, 4'h4, OP_OR);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_data",   {3'b0, res_valid, res_data}, 8'h1A);
      chk("bp_hold_ready",  {6'b0, req1_ready, req0_ready}, 8'h0);
      step();
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {6'b0, req1_ready, req0_ready}, 8'h2);
    sbq.push_back({1'b1, 4'h7});
    step();
    req1_valid = 1'b0;
    drain();

    // Async reset while BUSY: held result discarded, priority back to req0
    res_ready = 1'b0;
    set_req(1'b0, 4'h2, 4'h2, OP_ADD);
    @(negedge clk);
    chk("ar_accept_ready", {6'b0, req1_ready, req0_ready}, 8'h1);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("ar_busy_valid", {7'b0, res_valid}, 8'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid_cleared", {3'b0, res_valid, res_data}, 8'h00);
    step();
    reset = 1'b0;
    set_req(1'b0, 4'h1, 4'h1, OP_ADD);
    set_req(1'b1, 4'h7, 4'h2, OP_SUB);
    res_ready = 1'b1;
    @(negedge clk);
    chk("ar_first_grant", {6'b0, req1_ready, req0_ready}, 8'h1);
    sbq.push_back({1'b0, 4'h2});
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

`ifdef ALU_ARBITER_STATS_EN
    pulse_reset();
    chk("cnt0_reset", grant0_cnt, 8'h00);
    chk("cnt1_reset", grant1_cnt, 8'h00);
    set_req(1'b0, 4'h1, 4'h2, OP_OR);
    for (int k = 0; k < 300; k++) begin
      sbq.push_back({1'b0, 4'h3});
      step();
    end
    req0_valid = 1'b0;
    drain();
    chk("cnt0_saturated", grant0_cnt, 8'hFF);
    chk("cnt1_zero",      grant1_cnt, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
